uart_rx_pkt_ctrl: RTL

Packet-level controller that sits directly behind the UART receiver. It gates the receiver via rx_en and parses the byte stream into frames: SOF, LEN, payload, checksum. Payload is buffered and released on a valid/ready stream only after the checksum passes; a failed frame is discarded and reported.

---
 rtl/uart_rx_pkt_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_pkt_ctrl.sv
// Frame parser behind the UART receiver: SOF, LEN, payload, checksum; buffered payload released on valid/ready.
// Optional UART_PKT_BREAK_ABORT_EN: a receiver break inside a frame aborts it with err_code 4.
//
// state     | meaning
// S_IDLE    | hunting for SOF_BYTE, other bytes dropped
// S_LEN     | expecting length byte
// S_PAYLOAD | collecting payload into buffer, summing
// S_CHK     | expecting checksum byte
// S_DRAIN   | streaming buffered payload out, receiver gated off
module uart_rx_pkt_ctrl #(
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SOF_BYTE       = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter int         TO_W           = 17
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_break_i,
  output logic       rx_en_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [7:0] out_data_o,
  output logic       out_last_o,
  output logic       pkt_ok_o,
  output logic       pkt_err_o,
  output logic [2:0] err_code_o,
  output logic [7:0] pkt_len_o
);

  localparam int             IDX_W     = $clog2(MAX_LEN) + 1;
  localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TO_W-1:0] TO_LOAD  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_DRAIN} state_t;

  state_t           state_q;
  logic [7:0]       len_q, sum_q, out_data_q, pkt_len_q;
  logic [IDX_W-1:0] wr_idx_q, rd_idx_q;
  logic [TO_W-1:0]  to_q;
  logic             out_valid_q, out_last_q, pkt_ok_q, pkt_err_q;
  logic [2:0]       err_code_q;
  logic [7:0]       buf_q [MAX_LEN];

  logic             in_frame, to_tc, len_ok, last_wr, brk_abort, err_d;
  logic [7:0]       sum_d;
  logic [2:0]       code_d;
  logic [IDX_W-1:0] rd_idx_d;

  assign in_frame = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK);
  assign to_tc    = (to_q == '0);
  assign len_ok   = (rx_data_i != 8'd0) && (rx_data_i <= MAX_LEN_B);
  assign sum_d    = sum_q + rx_data_i;
  assign last_wr  = (8'(wr_idx_q) == len_q - 8'd1);
  assign rd_idx_d = rd_idx_q + IDX_W'(1);

`ifdef UART_PKT_BREAK_ABORT_EN
  assign brk_abort = in_frame && rx_valid_i && rx_break_i;
`else
  logic unused_brk;
  assign unused_brk = rx_break_i;
  assign brk_abort  = 1'b0;
`endif

  // Break beats data; an arriving byte beats the timeout terminal count.
  always_comb begin
    err_d  = 1'b0;
    code_d = 3'd0;
    if (brk_abort) begin
      err_d  = 1'b1;
      code_d = 3'd4;
    end else if (in_frame && rx_valid_i) begin
      if (state_q == S_LEN && !len_ok) begin
        err_d  = 1'b1;
        code_d = 3'd1;
      end else if (state_q == S_CHK && sum_d != 8'h00) begin
        err_d  = 1'b1;
        code_d = 3'd2;
      end
    end else if (in_frame && to_tc) begin
      err_d  = 1'b1;
      code_d = 3'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_PAYLOAD && rx_valid_i && !brk_abort)
      buf_q[wr_idx_q[IDX_W-2:0]] <= rx_data_i;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      len_q       <= 8'd0;
      sum_q       <= 8'd0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      to_q        <= TO_LOAD;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      out_last_q  <= 1'b0;
      pkt_ok_q    <= 1'b0;
      pkt_err_q   <= 1'b0;
      err_code_q  <= 3'd0;
      pkt_len_q   <= 8'd0;
    end else begin
      pkt_ok_q  <= 1'b0;
      pkt_err_q <= 1'b0;
      if (!in_frame || rx_valid_i)
        to_q <= TO_LOAD;
      else if (!to_tc)
        to_q <= to_q - TO_W'(1);

      if (err_d) begin
        state_q    <= S_IDLE;
        pkt_err_q  <= 1'b1;
        err_code_q <= code_d;
      end else begin
        case (state_q)
          S_IDLE:
            if (rx_valid_i && rx_data_i == SOF_BYTE) state_q <= S_LEN;
          S_LEN:
            if (rx_valid_i) begin
              len_q    <= rx_data_i;
              sum_q    <= rx_data_i;
              wr_idx_q <= '0;
              state_q  <= S_PAYLOAD;
            end
          S_PAYLOAD:
            if (rx_valid_i) begin
              sum_q    <= sum_d;
              wr_idx_q <= wr_idx_q + IDX_W'(1);
              if (last_wr) state_q <= S_CHK;
            end
          S_CHK:
            if (rx_valid_i) begin
              state_q     <= S_DRAIN;
              pkt_ok_q    <= 1'b1;
              pkt_len_q   <= len_q;
              out_valid_q <= 1'b1;
              out_data_q  <= buf_q[0];
              out_last_q  <= (len_q == 8'd1);
              rd_idx_q    <= '0;
            end
          S_DRAIN:
            if (out_ready_i) begin
              if (out_last_q) begin
                state_q     <= S_IDLE;
                out_valid_q <= 1'b0;
                out_data_q  <= 8'd0;
                out_last_q  <= 1'b0;
              end else begin
                rd_idx_q   <= rd_idx_d;
                out_data_q <= buf_q[rd_idx_d[IDX_W-2:0]];
                out_last_q <= (8'(rd_idx_d) == len_q - 8'd1);
              end
            end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign rx_en_o     = (state_q != S_DRAIN);
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign pkt_ok_o    = pkt_ok_q;
  assign pkt_err_o   = pkt_err_q;
  assign err_code_o  = err_code_q;
  assign pkt_len_o   = pkt_len_q;

endmodule
